// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the mux channel scanner.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } scan_state_e;

  // Select value of the last channel in a sweep.
  function automatic logic [SEL_W-1:0] last_ch();
    return SEL_W'(NUM_CH - 1);
  endfunction

endpackage

// File: rtl/mux4_1.sv
// 4:1 mux of 4-bit channels A..D steered by Sel.
module mux4_1 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [1:0] Sel,
  output logic [3:0] Y_out
);

  always_comb begin
    Y_out = A;
    case (Sel)
      2'd0:    Y_out = A;
      2'd1:    Y_out = B;
      2'd2:    Y_out = C;
      default: Y_out = D;
    endcase
  end

endmodule

// File: rtl/scan_dwell_cnt.sv
// Loadable down-counter with zero flag; times the mux settle window.
module scan_dwell_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mux_channel_scanner.sv
// Sweeps a 4:1 mux select, waits DWELL cycles per channel and hands samples over valid/ready.
// Optional SCAN_CHECKSUM_EN adds an 8-bit per-sweep sum output (sweep_sum).
module mux_channel_scanner
  import mux_scan_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DWELL  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              stop,
  input  logic [DATA_W-1:0] Y_in,
  output logic [SEL_W-1:0]  Sel,
  output logic [DATA_W-1:0] smp_data,
  output logic [SEL_W-1:0]  smp_ch,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              done,
`ifdef SCAN_CHECKSUM_EN
  output logic [7:0]        sweep_sum,
`endif
  output logic              busy
);

  scan_state_e       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] smp_data_q, smp_data_d;
  logic [SEL_W-1:0]  smp_ch_q, smp_ch_d;
  logic              smp_valid_q, smp_valid_d;
  logic              done_q, done_d;
  logic              cont_q, cont_d;

  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero_c;
  logic              xfer_c;

  scan_dwell_cnt #(.W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CNT_W'(DWELL)),
    .cnt      (cnt_val),
    .zero_c   (cnt_zero_c)
  );

  // A transfer is an accepted sample that stop has not discarded.
  assign xfer_c = (state_q == ST_HOLD) && smp_valid_q && smp_ready && !stop;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    smp_data_d  = smp_data_q;
    smp_ch_d    = smp_ch_q;
    smp_valid_d = smp_valid_q;
    done_d      = 1'b0;
    cont_d      = cont_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    if (stop) begin
      state_d     = ST_IDLE;
      smp_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cont_d   = cont;
            sel_d    = '0;
            cnt_load = 1'b1;
            state_d  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          cnt_dec = 1'b1;
          if ((cnt_val == CNT_W'(1)) || cnt_zero_c) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          smp_data_d  = Y_in;
          smp_ch_d    = sel_q;
          smp_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
        ST_HOLD: begin
          if (xfer_c) begin
            smp_valid_d = 1'b0;
            if (sel_q != last_ch()) begin
              sel_d    = sel_q + SEL_W'(1);
              cnt_load = 1'b1;
              state_d  = ST_SETTLE;
            end else if (cont_q) begin
              sel_d    = '0;
              cnt_load = 1'b1;
              state_d  = ST_SETTLE;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      smp_data_q  <= '0;
      smp_ch_q    <= '0;
      smp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cont_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      smp_data_q  <= smp_data_d;
      smp_ch_q    <= smp_ch_d;
      smp_valid_q <= smp_valid_d;
      done_q      <= done_d;
      cont_q      <= cont_d;
    end
  end

  assign Sel       = sel_q;
  assign smp_data  = smp_data_q;
  assign smp_ch    = smp_ch_q;
  assign smp_valid = smp_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef SCAN_CHECKSUM_EN
  logic [7:0] acc_q, acc_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] acc_plus;

  assign acc_plus = acc_q + 8'(smp_data_q);

  // Last-channel transfer publishes the sweep total and restarts accumulation.
  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    if (stop || ((state_q == ST_IDLE) && start)) begin
      acc_d = '0;
    end else if (xfer_c) begin
      if (smp_ch_q == last_ch()) begin
        sum_d = acc_plus;
        acc_d = '0;
      end else begin
        acc_d = acc_plus;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign sweep_sum = sum_q;
`endif

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed + randomized bench for mux_channel_scanner driven through mux4_1.
module tb_mux_channel_scanner;

  localparam int unsigned D = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cont, stop, smp_ready;
  logic [3:0] a, b, c, d, y;
  logic [1:0] sel, smp_ch;
  logic [3:0] smp_data;
  logic       smp_valid, done, busy;
`ifdef SCAN_CHECKSUM_EN
  logic [7:0] sweep_sum;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_ref = 0;
  bit done_seen = 1'b0;
  int sum_model = 0;
  logic [3:0] inp [4];

  always #5 clk = ~clk;

  mux4_1 u_mux (.A(a), .B(b), .C(c), .D(d), .Sel(sel), .Y_out(y));

  mux_channel_scanner #(.DATA_W(4), .DWELL(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cont      (cont),
    .stop      (stop),
    .Y_in      (y),
    .Sel       (sel),
    .smp_data  (smp_data),
    .smp_ch    (smp_ch),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .done      (done),
`ifdef SCAN_CHECKSUM_EN
    .sweep_sum (sweep_sum),
`endif
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_inputs(input logic [3:0] v0, input logic [3:0] v1,
                            input logic [3:0] v2, input logic [3:0] v3);
    inp[0] = v0; inp[1] = v1; inp[2] = v2; inp[3] = v3;
    a = v0; b = v1; c = v2; d = v3;
  endtask

  task automatic kick(input bit c_mode);
    cont = c_mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    t_ref = cyc;
    sum_model = 0;
    done_seen = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_sel", 32'(sel), 32'd0);
  endtask

  // Wait (bounded) until a sample is presented; return whether it appeared.
  task automatic wait_valid(output bit seen);
    int w;
    w = 0;
    while (smp_valid !== 1'b1 && w < 40) begin
      if (done === 1'b1) done_seen = 1'b1;
      tick();
      w++;
    end
    seen = (smp_valid === 1'b1);
  endtask

  // Expect n transfers in channel order from the current sweep position.
  task automatic collect(input int n, input int stall_k, input int stall_len, input bit last_done);
    bit seen;
    for (int k = 0; k < n; k++) begin
      wait_valid(seen);
      check("valid_seen", 32'(seen), 32'd1);
      check("latency", 32'(cyc - t_ref), 32'(D + 1));
      check("smp_ch", 32'(smp_ch), 32'(k % 4));
      check("smp_data", 32'(smp_data), 32'(inp[k % 4]));
      if (k == stall_k) begin
        smp_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_data", 32'(smp_data), 32'(inp[k % 4]));
          check("stall_ch", 32'(smp_ch), 32'(k % 4));
          check("stall_valid", 32'(smp_valid), 32'd1);
          check("stall_sel", 32'(sel), 32'(k % 4));
        end
        smp_ready = 1'b1;
      end
      tick();
      t_ref = cyc;
      sum_model = (sum_model + int'(inp[k % 4])) % 256;
      if (k == n - 1 && last_done) begin
        check("done_pulse", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_sel", 32'(sel), 32'd3);
      end else begin
        check("xfer_valid", 32'(smp_valid), 32'd0);
        check("next_sel", 32'(sel), 32'((k + 1) % 4));
        check("no_done", 32'(done), 32'd0);
      end
      if (k % 4 == 3) begin
`ifdef SCAN_CHECKSUM_EN
        check("sweep_sum", 32'(sweep_sum), 32'(sum_model));
`endif
        sum_model = 0;
      end
    end
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; stop = 1'b0; smp_ready = 1'b1;
    set_inputs(4'd1, 4'd2, 4'd3, 4'd4);
    #3;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_valid", 32'(smp_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single sweep 1,2,3,4.
    kick(1'b0);
    collect(4, -1, 0, 1'b1);
    tick();
    check("done_once", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Second sweep of all-15 (sum 60), then backpressure at ch1.
    set_inputs(4'd15, 4'd15, 4'd15, 4'd15);
    kick(1'b0);
    collect(4, -1, 0, 1'b1);
    tick();
    set_inputs(4'd1, 4'd2, 4'd3, 4'd4);
    kick(1'b0);
    collect(4, 1, 10, 1'b1);
    tick();

    // Continuous: 9 transfers, done must never pulse, then stop.
    kick(1'b1);
    collect(9, -1, 0, 1'b0);
    check("cont_no_done", 32'(done_seen), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("cont_stop_busy", 32'(busy), 32'd0);
    check("cont_stop_sel", 32'(sel), 32'd1);
    tick();

    // Abort in HOLD at ch2 with ready high.
    kick(1'b0);
    collect(2, -1, 0, 1'b0);
    wait_valid(seen);
    check("abort_ch", 32'(smp_ch), 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("abort_valid", 32'(smp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sel", 32'(sel), 32'd2);
    check("abort_done", 32'(done), 32'd0);
    tick();
    check("abort_done2", 32'(done), 32'd0);

    // start together with stop in IDLE stays idle.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 32'd0);

    // Reset mid-SETTLE of ch1: outputs clear before any edge, rescan from ch0.
    kick(1'b0);
    collect(1, -1, 0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 32'(sel), 32'd0);
    check("mid_rst_data", 32'(smp_data), 32'd0);
    check("mid_rst_ch", 32'(smp_ch), 32'd0);
    check("mid_rst_valid", 32'(smp_valid), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
`ifdef SCAN_CHECKSUM_EN
    check("mid_rst_sum", 32'(sweep_sum), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    kick(1'b0);
    collect(4, -1, 0, 1'b1);
    tick();

    // Randomized sweeps with random stalls and modes.
    for (int r = 0; r < 6; r++) begin
      bit c_mode;
      int n;
      set_inputs(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      c_mode = 1'($urandom);
      n = c_mode ? int'($urandom_range(5, 9)) : 4;
      kick(c_mode);
      collect(n, int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), !c_mode);
      if (c_mode) begin
        check("rnd_no_done", 32'(done_seen), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("rnd_stop_busy", 32'(busy), 32'd0);
        check("rnd_stop_sel", 32'(sel), 32'(n % 4));
      end
      tick();
      check("rnd_done_low", 32'(done), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
